// File: rtl/cfg_frame_pkg.sv
// Shared types and constants for the configuration frame controller:
// FSM state encoding, default sync word and address-word field positions.
package cfg_frame_pkg;

  typedef enum logic [1:0] {
    DESYNC = 2'd0,
    ADDR   = 2'd1,
    DATA   = 2'd2,
    STROBE = 2'd3
  } cfg_state_e;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

  localparam int unsigned ADDR_DESYNC_BIT = 31;
  localparam int unsigned ADDR_COL_LSB    = 16;

endpackage

// File: rtl/frame_index_decode.sv
// Combinational frame-index to one-hot decoder with an in-range flag.
// Out-of-range indices decode to an all-zero vector.
module frame_index_decode #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned IndexWidth      = 5
) (
  input  logic [IndexWidth-1:0]      index_i,
  output logic [MaxFramesPerCol-1:0] onehot_c,
  output logic                       valid_c
);

  always_comb begin
    onehot_c = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      onehot_c[i] = (index_i == IndexWidth'(i));
    end
    valid_c = (32'(index_i) < MaxFramesPerCol);
  end

endmodule

// File: rtl/config_frame_ctrl.sv
// Configuration frame controller: parses sync/address/data/desync words into
// row writes and a column-addressed frame strobe. FRAME_CTRL_INDEX_CHECK_EN
// enables the frame-index range check and sticky ConfigError.
module config_frame_ctrl
  import cfg_frame_pkg::*;
#(
  parameter int unsigned NumberOfRows     = 16,
  parameter int unsigned RowSelectWidth   = 5,
  parameter int unsigned MaxFramesPerCol  = 20,
  parameter int unsigned FrameSelectWidth = 5,
  parameter logic [31:0] SyncWord         = SYNC_WORD_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [31:0]                 WriteData,
  input  logic                        WriteStrobe,
  output logic                        WriteReady,
  output logic [RowSelectWidth-1:0]   RowSelect,
  output logic [31:0]                 RowWriteData,
  output logic                        RowWriteStrobe,
  output logic [FrameSelectWidth-1:0] FrameSelect,
  output logic                        FrameStrobe,
  output logic [MaxFramesPerCol-1:0]  FrameStrobe_O,
  output logic                        ConfigActive,
  output logic                        ConfigError
);

  localparam int unsigned FIW = $clog2(MaxFramesPerCol);

  cfg_state_e state_q, state_d;
  logic [RowSelectWidth-1:0]   row_cnt_q, row_cnt_d;
  logic [FrameSelectWidth-1:0] col_q, col_d;
  logic [FIW-1:0]              idx_q, idx_d;

  logic                        write_ready_q, write_ready_d;
  logic [RowSelectWidth-1:0]   row_select_q, row_select_d;
  logic [31:0]                 row_write_data_q, row_write_data_d;
  logic                        row_write_strobe_q, row_write_strobe_d;
  logic [FrameSelectWidth-1:0] frame_select_q, frame_select_d;
  logic                        frame_strobe_q, frame_strobe_d;
  logic [MaxFramesPerCol-1:0]  frame_strobe_o_q, frame_strobe_o_d;
  logic                        config_active_q, config_active_d;
  logic                        config_error_q, config_error_d;

  logic                        accept;
  logic [MaxFramesPerCol-1:0]  idx_onehot;
  logic                        idx_valid;

  frame_index_decode #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .IndexWidth     (FIW)
  ) u_index_decode (
    .index_i (idx_q),
    .onehot_c(idx_onehot),
    .valid_c (idx_valid)
  );

`ifndef FRAME_CTRL_INDEX_CHECK_EN
  logic unused_idx_valid;
  assign unused_idx_valid = idx_valid;
`endif

  assign accept = WriteStrobe && write_ready_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d            = state_q;
    row_cnt_d          = row_cnt_q;
    col_d              = col_q;
    idx_d              = idx_q;
    row_select_d       = row_select_q;
    row_write_data_d   = row_write_data_q;
    row_write_strobe_d = 1'b0;
    frame_select_d     = frame_select_q;
    frame_strobe_d     = 1'b0;
    frame_strobe_o_d   = '0;
    config_error_d     = config_error_q;

    unique case (state_q)
      DESYNC: begin
        if (accept && (WriteData == SyncWord)) begin
          state_d        = ADDR;
          config_error_d = 1'b0;
        end
      end
      ADDR: begin
        if (accept) begin
          if (WriteData[ADDR_DESYNC_BIT]) begin
            state_d = DESYNC;
          end else begin
            col_d     = WriteData[ADDR_COL_LSB +: FrameSelectWidth];
            idx_d     = WriteData[FIW-1:0];
            row_cnt_d = '0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          row_select_d       = row_cnt_q;
          row_write_data_d   = WriteData;
          row_write_strobe_d = 1'b1;
          if (row_cnt_q == RowSelectWidth'(NumberOfRows - 1)) begin
            state_d = STROBE;
          end else begin
            row_cnt_d = row_cnt_q + RowSelectWidth'(1);
          end
        end
      end
      STROBE: begin
        state_d        = ADDR;
        frame_select_d = col_q;
`ifdef FRAME_CTRL_INDEX_CHECK_EN
        if (idx_valid) begin
          frame_strobe_d   = 1'b1;
          frame_strobe_o_d = idx_onehot;
        end else begin
          config_error_d = 1'b1;
        end
`else
        frame_strobe_d   = 1'b1;
        frame_strobe_o_d = idx_onehot;
`endif
      end
      default: state_d = DESYNC;
    endcase

`ifndef FRAME_CTRL_INDEX_CHECK_EN
    config_error_d = 1'b0;
`endif

    write_ready_d   = (state_d != STROBE);
    config_active_d = (state_d != DESYNC);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q            <= DESYNC;
      row_cnt_q          <= '0;
      col_q              <= '0;
      idx_q              <= '0;
      write_ready_q      <= 1'b1;
      row_select_q       <= '0;
      row_write_data_q   <= '0;
      row_write_strobe_q <= 1'b0;
      frame_select_q     <= '0;
      frame_strobe_q     <= 1'b0;
      frame_strobe_o_q   <= '0;
      config_active_q    <= 1'b0;
      config_error_q     <= 1'b0;
    end else begin
      state_q            <= state_d;
      row_cnt_q          <= row_cnt_d;
      col_q              <= col_d;
      idx_q              <= idx_d;
      write_ready_q      <= write_ready_d;
      row_select_q       <= row_select_d;
      row_write_data_q   <= row_write_data_d;
      row_write_strobe_q <= row_write_strobe_d;
      frame_select_q     <= frame_select_d;
      frame_strobe_q     <= frame_strobe_d;
      frame_strobe_o_q   <= frame_strobe_o_d;
      config_active_q    <= config_active_d;
      config_error_q     <= config_error_d;
    end
  end

  assign WriteReady     = write_ready_q;
  assign RowSelect      = row_select_q;
  assign RowWriteData   = row_write_data_q;
  assign RowWriteStrobe = row_write_strobe_q;
  assign FrameSelect    = frame_select_q;
  assign FrameStrobe    = frame_strobe_q;
  assign FrameStrobe_O  = frame_strobe_o_q;
  assign ConfigActive   = config_active_q;
  assign ConfigError    = config_error_q;

endmodule

// File: tb/tb_config_frame_ctrl.sv
// Scoreboard bench for config_frame_ctrl: stimulus pushes expected row writes
// and frame strobes; a negedge monitor pops and compares them.
module tb_config_frame_ctrl;

  logic        CLK;
  logic        RESET;
  logic [31:0] WriteData;
  logic        WriteStrobe;
  logic        WriteReady;
  logic [4:0]  RowSelect;
  logic [31:0] RowWriteData;
  logic        RowWriteStrobe;
  logic [4:0]  FrameSelect;
  logic        FrameStrobe;
  logic [19:0] FrameStrobe_O;
  logic        ConfigActive;
  logic        ConfigError;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  int checks   = 0;
  int failures = 0;
  int ready_low = 0;
  bit prev_last_row = 1'b0;

  logic [36:0] row_q[$];    // {row, data}
  logic [24:0] frame_q[$];  // {column, one-hot}

  config_frame_ctrl dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .WriteData     (WriteData),
    .WriteStrobe   (WriteStrobe),
    .WriteReady    (WriteReady),
    .RowSelect     (RowSelect),
    .RowWriteData  (RowWriteData),
    .RowWriteStrobe(RowWriteStrobe),
    .FrameSelect   (FrameSelect),
    .FrameStrobe   (FrameStrobe),
    .FrameStrobe_O (FrameStrobe_O),
    .ConfigActive  (ConfigActive),
    .ConfigError   (ConfigError)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops scoreboard entries whenever the DUT strobes
  always @(negedge CLK) begin
    logic [36:0] re;
    logic [24:0] fe;
    if (RESET) begin
      prev_last_row = 1'b0;
    end else begin
      if (RowWriteStrobe) begin
        if (row_q.size() == 0) begin
          chk("row_unexpected", 64'(RowSelect), 64'hDEAD);
        end else begin
          re = row_q.pop_front();
          chk("row_select", 64'(RowSelect), 64'(re[36:32]));
          chk("row_data", 64'(RowWriteData), 64'(re[31:0]));
        end
      end
      if (FrameStrobe) begin
        if (frame_q.size() == 0) begin
          chk("frame_unexpected", 64'(FrameSelect), 64'hDEAD);
        end else begin
          fe = frame_q.pop_front();
          chk("frame_select", 64'(FrameSelect), 64'(fe[24:20]));
          chk("frame_onehot", 64'(FrameStrobe_O), 64'(fe[19:0]));
          chk("frame_after_last_row", 64'(prev_last_row), 64'd1);
        end
      end
      chk("strobe_exclusive", 64'(RowWriteStrobe & FrameStrobe), 64'd0);
      chk("onehot_qualified", 64'(!FrameStrobe && (FrameStrobe_O != '0)), 64'd0);
      if (!WriteReady) ready_low++;
      prev_last_row = RowWriteStrobe && (RowSelect == 5'd15);
    end
  end

  task automatic send(input logic [31:0] w);
    bit rdy;
    rdy = 1'b0;
    WriteData   = w;
    WriteStrobe = 1'b1;
    for (int n = 0; n < 16 && !rdy; n++) begin
      @(negedge CLK);
      rdy = WriteReady;
      @(posedge CLK);
      #1;
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted word=%0h", w);
    end
  endtask

  task automatic idle(input int n);
    WriteStrobe = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_rows(input int count, input logic [31:0] base);
    for (int k = 0; k < count; k++) begin
      send(base + 32'(k));
      row_q.push_back({5'(k), base + 32'(k)});
    end
  endtask

  task automatic do_frame(input logic [4:0] col, input logic [4:0] idx,
                          input logic [19:0] onehot, input bit expect_strobe,
                          input logic [31:0] base);
    send((32'(col) << 16) | 32'(idx));
    send_rows(16, base);
    if (expect_strobe) frame_q.push_back({col, onehot});
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ready"}, 64'(WriteReady), 64'd1);
    chk({tag, "_row"}, {26'd0, RowSelect, RowWriteData, RowWriteStrobe}, 64'd0);
    chk({tag, "_frame"}, {35'd0, FrameSelect, FrameStrobe, FrameStrobe_O, ConfigActive, ConfigError}, 64'd0);
  endtask

  initial begin
    int base_low;
    RESET       = 1'b1;
    WriteData   = '0;
    WriteStrobe = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outs("reset");
    RESET = 1'b0;
    idle(2);
    check_reset_outs("post_reset");

    // Non-sync word in DESYNC is ignored
    send(32'h1234_5678);
    idle(3);
    chk("ignored_active", 64'(ConfigActive), 64'd0);

    // Single frame: column 3, index 7, data 0..15
    send(SYNC);
    chk("sync_active", 64'(ConfigActive), 64'd1);
    do_frame(5'd3, 5'd7, 20'h00080, 1'b1, 32'd0);
    idle(4);
    chk("frame1_drained", 64'(row_q.size() + frame_q.size()), 64'd0);
    chk("frame1_ready_low", 64'(ready_low), 64'd1);

    // Back-to-back frames with WriteStrobe held high
    base_low = ready_low;
    do_frame(5'd5, 5'd0, 20'h00001, 1'b1, 32'hA000_0000);
    do_frame(5'd17, 5'd19, 20'h80000, 1'b1, 32'hB000_0000);
    idle(4);
    chk("b2b_drained", 64'(row_q.size() + frame_q.size()), 64'd0);
    chk("b2b_ready_low", 64'(ready_low - base_low), 64'd2);

    // Out-of-range index 25
`ifdef FRAME_CTRL_INDEX_CHECK_EN
    do_frame(5'd9, 5'd25, 20'h0, 1'b0, 32'h5000_0000);
    idle(4);
    chk("idx25_error", 64'(ConfigError), 64'd1);
`else
    do_frame(5'd9, 5'd25, 20'h0, 1'b1, 32'h5000_0000);
    idle(4);
    chk("idx25_error", 64'(ConfigError), 64'd0);
`endif
    chk("idx25_drained", 64'(row_q.size() + frame_q.size()), 64'd0);

    // Desync address word, then data is ignored
    send(32'h8000_0000);
    chk("desync_active", 64'(ConfigActive), 64'd0);
    send(32'h0000_0011);
    send(32'h0000_0022);
    send(32'h0003_0007);
    idle(3);
`ifdef FRAME_CTRL_INDEX_CHECK_EN
    chk("error_sticky", 64'(ConfigError), 64'd1);
`endif
    send(SYNC);
    chk("resync_error_clear", 64'(ConfigError), 64'd0);
    chk("resync_active", 64'(ConfigActive), 64'd1);

    // Reset mid-frame after data word 8
    send((32'd1 << 16) | 32'd2);
    send_rows(9, 32'h7700_0000);
    RESET = 1'b1;
    WriteStrobe = 1'b0;
    #1;
    check_reset_outs("mid_reset");
    row_q.delete();
    frame_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle(3);
    check_reset_outs("after_abort");

    send(SYNC);
    do_frame(5'd31, 5'd19, 20'h80000, 1'b1, 32'hC0DE_0000);
    idle(5);
    chk("final_drained", 64'(row_q.size() + frame_q.size()), 64'd0);
    chk("total_ready_low", 64'(ready_low), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_frame_ctrl.md
# config_frame_ctrl

Configuration frame controller for the eFPGA fabric. It sits directly upstream of the per-column frame-select stage. It parses the incoming 32-bit configuration word stream (sync, frame address, row data, desync) and drives two sets of outputs:
- the row data-register write interface;
- the column-addressed frame strobe (`FrameSelect`, `FrameStrobe`, one-hot frame strobe vector) that each column's frame-select stage qualifies against its own column index.

## Interface
Parameters:
- `NumberOfRows`, 16: fabric rows; data words per frame.
- `RowSelectWidth`, 5: width of `RowSelect`; must satisfy 2^RowSelectWidth ≥ NumberOfRows.
- `MaxFramesPerCol`, 20: frames per column; width of the one-hot strobe.
- `FrameSelectWidth`, 5: column address width.
- `SyncWord`, 32'hFAB0_FAB1: word that enters synced mode.

Ports (one clock; reset is asynchronous and active-high):
- `CLK` in 1: configuration clock; all state on rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `WriteData` in 32: configuration word.
- `WriteStrobe` in 1: word valid.
- `WriteReady` out 1: word accepted when `WriteStrobe && WriteReady`.
- `RowSelect` out RowSelectWidth: target row of `RowWriteData`.
- `RowWriteData` out 32: row frame data.
- `RowWriteStrobe` out 1: single-cycle write enable for the selected row's data register.
- `FrameSelect` out FrameSelectWidth: target column.
- `FrameStrobe` out 1: single-cycle frame commit pulse.
- `FrameStrobe_O` out MaxFramesPerCol: one-hot frame index; nonzero only while `FrameStrobe` is high.
- `ConfigActive` out 1: high while synced.
- `ConfigError` out 1: sticky frame-index error flag.

## Operation
- States: `DESYNC`, `ADDR`, `DATA`, `STROBE`. Reset state is `DESYNC`.
- **`DESYNC`**
  - `WriteReady` = 1.
  - A word equal to `SyncWord` goes to `ADDR` and clears `ConfigError`.
  - Any other word is consumed and ignored.
- **`ADDR`**: the accepted word is decoded as a frame address word.
  - bit 31 = desync flag. If set, go to `DESYNC`; other fields are ignored.
  - bits [16+FrameSelectWidth-1:16] = column.
  - bits [FIW-1:0] = frame index, where FIW = $clog2(MaxFramesPerCol).
  - Column and index are latched. Row counter is cleared to 0. Go to `DATA`.
- **`DATA`**
  - Each accepted word k (k = 0..NumberOfRows-1) produces `RowSelect`=k and `RowWriteData`=word, with `RowWriteStrobe` high for one cycle.
  - After word NumberOfRows-1, go to `STROBE`.
- **`STROBE`**
  - Lasts one cycle with `WriteReady` = 0.
  - Issues the `FrameStrobe` pulse with the latched column and the one-hot decoded index, then returns to `ADDR`.
- The row counter wraps only by returning through `ADDR`. It never exceeds NumberOfRows-1.
- A `SyncWord` value seen in `ADDR` or `DATA` is treated as ordinary data or address; it has no special meaning there.
- Reset asserted mid-frame aborts the frame: no strobe is issued, the FSM returns to `DESYNC`, and outputs clear.

## Timing
- Reset values:
  - `WriteReady`=1.
  - All other outputs 0, including `RowSelect`, `RowWriteData`, `FrameSelect` and `FrameStrobe_O`.
- All outputs are registered.
- Latency:
  - An accepted data word in cycle t appears on the row interface in cycle t+1.
  - `ConfigActive` rises in the cycle after `SyncWord` is accepted.
  - `ConfigActive` falls in the cycle after a desync word is accepted.
- End of frame:
  - Last data word accepted at t.
  - t+1: `RowWriteStrobe` high (last row), state `STROBE`, `WriteReady`=0.
  - t+2: `FrameStrobe`=1, `FrameSelect`=column, `FrameStrobe_O`=one-hot index, `WriteReady`=1.
  - `FrameStrobe` is therefore always exactly one cycle after the last row write.
- Back-to-back frames: an address word may be accepted at t+2.
- Gaps in `WriteStrobe` stall the FSM without side effects.
- `RowWriteStrobe` and `FrameStrobe` are never high in the same cycle.

## Configuration
- `FRAME_CTRL_INDEX_CHECK_EN` defined:
  - A frame index ≥ MaxFramesPerCol sets `ConfigError`.
  - The frame's data words are still written, but the `STROBE` cycle keeps `FrameStrobe`=0 and `FrameStrobe_O`=0.
  - `ConfigError` stays set until the next `SyncWord` or reset.
- Not defined:
  - No index check; `ConfigError` is tied to 0.
  - An out-of-range index strobes with `FrameStrobe`=1 and `FrameStrobe_O`=0.

## Structure
- Package `cfg_frame_pkg` holds:
  - FSM state enum;
  - default `SyncWord`;
  - address-word field positions (desync bit 31, column LSB 16).
- Sub-module `frame_index_decode`: combinational index-to-one-hot decoder of width MaxFramesPerCol, with a range-valid output. Its outputs are registered in the parent.

## Test plan
- Reset, then `WriteData`=32'h1234_5678 with `WriteStrobe`=1 → ignored; `ConfigActive`=0 and no row or frame strobes.
- `SyncWord`; address word with column 3, index 7; 16 data words 0..15 → `RowWriteStrobe` on rows 0..15 with matching data. Two cycles after the last word: `FrameStrobe`=1, `FrameSelect`=3, `FrameStrobe_O`=20'h00080 for one cycle.
- Two frames back-to-back with `WriteStrobe` held high → `WriteReady` low exactly one cycle per frame; the second frame's strobe carries its own column and index.
- Index 25, with `FRAME_CTRL_INDEX_CHECK_EN` defined → `ConfigError`=1, no `FrameStrobe`; the next `SyncWord` clears `ConfigError`.
- Address word 32'h8000_0000 → `ConfigActive` falls next cycle; further data words produce no strobes.
- `RESET` pulse after data word 8 → all outputs 0; a new `SyncWord` and full frame complete normally.
